// File: rtl/adc_ring_pkg.sv
// Shared types and constants for the ADC acquisition / ring-buffer writer.
package adc_ring_pkg;

   localparam int ADC_W = 12;

   localparam logic [11:0] DEF_EMG_BASE = 12'hC7F;
   localparam logic [11:0] DEF_ECG_BASE = 12'h801;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_EMG = 2'd1,
      WR_ECG = 2'd2
   } wr_state_t;

endpackage

// File: rtl/adc_ring_writer_if.sv
// RAM port B bundle shared between the ring writer (master) and the RAM (slave).
interface adc_ring_writer_if;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport master (output ram_we, output ram_addr, output ram_wdata, input ram_rdata);
   modport slave  (input ram_we, input ram_addr, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/sample_averager.sv
// Boxcar accumulator for one channel; avg is the mean including the sample on this tick.
module sample_averager
   import adc_ring_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick,
   input  logic             done,
   input  logic [ADC_W-1:0] sample,
   output logic [ADC_W-1:0] avg
);

   localparam int ACC_W = ADC_W + AVG_LOG2;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;

   // Sum cannot overflow: 2^AVG_LOG2 full-scale samples fit exactly in ACC_W bits.
   assign acc_sum = acc + ACC_W'(sample);
   assign avg     = acc_sum[ACC_W-1:AVG_LOG2];

   always_ff @(posedge clock) begin
      if (reset) begin
         acc <= '0;
      end else if (tick) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         acc <= done ? '0 : acc_sum;
      end
   end

endmodule

// File: rtl/adc_ring_writer.sv
// Paces ADC sampling, averages EMG/ECG and writes both into circular RAM buffers,
// time-sharing RAM port B with the VGA read path.
module adc_ring_writer
   import adc_ring_pkg::*;
#(
   parameter int          SUB_INTERVAL = 31250,
   parameter int          AVG_LOG2     = 2,
   parameter int          DEPTH        = 640,
   parameter logic [11:0] EMG_BASE     = DEF_EMG_BASE,
   parameter logic [11:0] ECG_BASE     = DEF_ECG_BASE
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [31:0]               emg_in,
   input  logic [31:0]               ecg_in,
   input  logic                      freeze,
   input  logic [11:0]               vga_addr,
   output logic [31:0]               vga_data,
   output logic                      vga_valid,
   adc_ring_writer_if.master         ram,
   output logic [9:0]                emg_ptr,
   output logic [9:0]                ecg_ptr,
   output logic                      frame_done
);

   localparam int         DIV_W    = (SUB_INTERVAL > 1) ? $clog2(SUB_INTERVAL) : 1;
   localparam int         CNT_W    = AVG_LOG2 + 1;
   localparam logic [9:0] LAST_IDX = 10'(DEPTH - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [CNT_W-1:0] sample_cnt;
   logic             done;
   logic [ADC_W-1:0] emg_avg_now;
   logic [ADC_W-1:0] ecg_avg_now;
   logic [ADC_W-1:0] avg_emg;
   logic [ADC_W-1:0] avg_ecg;
   logic [31:0]      vga_hold;
   wr_state_t        state;

   logic unused_in_bits;
   assign unused_in_bits = ^{emg_in[31:ADC_W], ecg_in[31:ADC_W]};

   function automatic logic [9:0] next_idx(input logic [9:0] idx);
      return (idx == LAST_IDX) ? 10'd0 : idx + 10'd1;
   endfunction

   assign tick = (div_cnt == DIV_W'(SUB_INTERVAL - 1));
   assign done = (sample_cnt == CNT_W'((1 << AVG_LOG2) - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt    <= '0;
         sample_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) begin
            sample_cnt <= done ? '0 : sample_cnt + CNT_W'(1);
         end
      end
   end

   sample_averager #(.AVG_LOG2(AVG_LOG2)) u_emg_avg (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .done   (done),
      .sample (emg_in[ADC_W-1:0]),
      .avg    (emg_avg_now)
   );

   sample_averager #(.AVG_LOG2(AVG_LOG2)) u_ecg_avg (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .done   (done),
      .sample (ecg_in[ADC_W-1:0]),
      .avg    (ecg_avg_now)
   );

   // Port B outputs are registered alongside the state they belong to.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         ram.ram_we    <= 1'b0;
         ram.ram_addr  <= '0;
         ram.ram_wdata <= '0;
         emg_ptr       <= '0;
         ecg_ptr       <= '0;
         frame_done    <= 1'b0;
         avg_emg       <= '0;
         avg_ecg       <= '0;
      end else begin
         frame_done <= 1'b0;
         if (tick && done) begin
            avg_emg <= emg_avg_now;
            avg_ecg <= ecg_avg_now;
         end
         case (state)
            IDLE: begin
               if (tick && done && !freeze) begin
                  state         <= WR_EMG;
                  ram.ram_we    <= 1'b1;
                  ram.ram_addr  <= EMG_BASE + {2'b00, emg_ptr};
                  ram.ram_wdata <= 32'(emg_avg_now);
               end else begin
                  ram.ram_we   <= 1'b0;
                  ram.ram_addr <= vga_addr;
               end
            end
            WR_EMG: begin
               state         <= WR_ECG;
               ram.ram_we    <= 1'b1;
               ram.ram_addr  <= ECG_BASE + {2'b00, ecg_ptr};
               ram.ram_wdata <= 32'(avg_ecg);
               emg_ptr       <= next_idx(emg_ptr);
            end
            WR_ECG: begin
               state        <= IDLE;
               ram.ram_we   <= 1'b0;
               ram.ram_addr <= vga_addr;
               ecg_ptr      <= next_idx(ecg_ptr);
               frame_done   <= (ecg_ptr == LAST_IDX);
            end
            default: begin
               state        <= IDLE;
               ram.ram_we   <= 1'b0;
               ram.ram_addr <= vga_addr;
            end
         endcase
      end
   end

   // Read data lags the address by one cycle, hence the registered valid flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         vga_valid <= 1'b0;
         vga_hold  <= '0;
      end else begin
         vga_valid <= (state == IDLE);
         if (vga_valid) begin
            vga_hold <= ram.ram_rdata;
         end
      end
   end

   assign vga_data = vga_valid ? ram.ram_rdata : vga_hold;

endmodule

// File: tb/tb_adc_ring_writer.sv
// Directed bench for adc_ring_writer with a small port-B RAM model.
module tb_adc_ring_writer;

   localparam int SUB   = 8;
   localparam int LOG2  = 2;
   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0][11:0] emg;
      logic [3:0][11:0] ecg;
      logic [31:0]      exp_emg;
      logic [31:0]      exp_ecg;
      logic [11:0]      exp_emg_addr;
      logic [11:0]      exp_ecg_addr;
      logic [9:0]       exp_ptr;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] emg_in = '0;
   logic [31:0] ecg_in = '0;
   logic        freeze = 1'b0;
   logic [11:0] vga_addr = 12'h010;
   logic [31:0] vga_data;
   logic        vga_valid;
   logic [9:0]  emg_ptr;
   logic [9:0]  ecg_ptr;
   logic        frame_done;

   adc_ring_writer_if ram_bus ();

   adc_ring_writer #(
      .SUB_INTERVAL (SUB),
      .AVG_LOG2     (LOG2),
      .DEPTH        (DEPTH),
      .EMG_BASE     (12'hC7F),
      .ECG_BASE     (12'h801)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .emg_in     (emg_in),
      .ecg_in     (ecg_in),
      .freeze     (freeze),
      .vga_addr   (vga_addr),
      .vga_data   (vga_data),
      .vga_valid  (vga_valid),
      .ram        (ram_bus),
      .emg_ptr    (emg_ptr),
      .ecg_ptr    (ecg_ptr),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [4096];

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'h010] = 32'h0000ABCD;
   end

   always @(posedge clock) begin
      if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
      ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
   end

   // Cycle index since the last reset edge; cycle 0 is the first cycle out of reset.
   int cyc;
   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   wr_t wr_q[$];
   int  fd_q[$];
   int  checks = 0;
   int  errors = 0;
   logic vga_mon_en = 1'b0;
   int  vga_bad = 0;
   int  vga_low = 0;

   always @(negedge clock) begin
      wr_t w;
      if (ram_bus.ram_we) begin
         w.cyc  = cyc;
         w.addr = ram_bus.ram_addr;
         w.data = ram_bus.ram_wdata;
         wr_q.push_back(w);
      end
      if (frame_done) fd_q.push_back(cyc);
      if (vga_mon_en && cyc >= 4 && cyc <= 194) begin
         logic exp_v;
         exp_v = !(((cyc % 32) == 1 || (cyc % 32) == 2) && cyc >= 33);
         if (vga_valid !== exp_v || vga_data !== 32'h0000ABCD) vga_bad++;
         if (vga_valid == 1'b0) vga_low++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cyc != target && n < 500);
      if (cyc != target) check("wait_timeout", cyc, target);
   endtask

   task automatic expect_write(input string name, input int exp_cyc,
                               input logic [11:0] exp_addr, input logic [31:0] exp_data);
      wr_t w;
      if (wr_q.size() != 0) begin
         w = wr_q.pop_front();
         check({name, "_cycle"}, w.cyc, exp_cyc);
         check({name, "_addr"}, 32'(w.addr), 32'(exp_addr));
         check({name, "_data"}, w.data, exp_data);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      wr_q.delete();
      fd_q.delete();
      reset = 1'b0;
   endtask

   vec_t vecs [6];

   task automatic set_vec(input int i, input logic [3:0][11:0] e, input logic [3:0][11:0] c,
                          input logic [31:0] xe, input logic [31:0] xc,
                          input logic [11:0] ae, input logic [11:0] ac, input logic [9:0] p);
      vecs[i].emg = e;
      vecs[i].ecg = c;
      vecs[i].exp_emg = xe;
      vecs[i].exp_ecg = xc;
      vecs[i].exp_emg_addr = ae;
      vecs[i].exp_ecg_addr = ac;
      vecs[i].exp_ptr = p;
   endtask

   initial begin
      // Samples listed as {s3, s2, s1, s0}; s0 is taken first.
      set_vec(0, {12'd100, 12'd100, 12'd100, 12'd100}, {12'd200, 12'd200, 12'd200, 12'd200},
              32'd100, 32'd200, 12'hC7F, 12'h801, 10'd1);
      set_vec(1, {12'd6, 12'd3, 12'd2, 12'd1}, {12'd3, 12'd0, 12'd0, 12'd0},
              32'd3, 32'd0, 12'hC80, 12'h802, 10'd2);
      set_vec(2, {12'd4095, 12'd4095, 12'd4095, 12'd4095}, {12'd4094, 12'd4095, 12'd4095, 12'd4095},
              32'd4095, 32'd4094, 12'hC81, 12'h803, 10'd3);
      set_vec(3, {12'd0, 12'd0, 12'd0, 12'd0}, {12'd13, 12'd12, 12'd11, 12'd10},
              32'd0, 32'd11, 12'hC82, 12'h804, 10'd0);
      set_vec(4, {12'd2049, 12'd2048, 12'd2048, 12'd2048}, {12'd1, 12'd1, 12'd1, 12'd1},
              32'd2048, 32'd1, 12'hC7F, 12'h801, 10'd1);
      set_vec(5, {12'd5, 12'd5, 12'd5, 12'd5}, {12'd200, 12'd200, 12'd200, 12'd200},
              32'd5, 32'd200, 12'hC80, 12'h802, 10'd2);

      // Reset state, sampled while reset is still held.
      repeat (3) @(negedge clock);
      check("rst_ram_we", 32'(ram_bus.ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_bus.ram_addr), 32'd0);
      check("rst_ram_wdata", ram_bus.ram_wdata, 32'd0);
      check("rst_vga_valid", 32'(vga_valid), 32'd0);
      check("rst_vga_data", vga_data, 32'd0);
      check("rst_emg_ptr", 32'(emg_ptr), 32'd0);
      check("rst_ecg_ptr", 32'(ecg_ptr), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      do_reset();

      // Averaging, addressing and wrap across six back-to-back windows.
      vga_mon_en = 1'b1;
      for (int j = 0; j < 6; j++) begin
         for (int k = 0; k < 4; k++) begin
            wait_cyc(32 * j + 8 * k + 4);
            emg_in = {20'hA5A5A, vecs[j].emg[k]};
            ecg_in = {20'h5A5A5, vecs[j].ecg[k]};
         end
         wait_cyc(32 * j + 35);
         check($sformatf("w%0d_wr_count", j), wr_q.size(), 2);
         expect_write($sformatf("w%0d_emg", j), 32 * (j + 1), vecs[j].exp_emg_addr, vecs[j].exp_emg);
         expect_write($sformatf("w%0d_ecg", j), 32 * (j + 1) + 1, vecs[j].exp_ecg_addr, vecs[j].exp_ecg);
         wr_q.delete();
         check($sformatf("w%0d_emg_ptr", j), 32'(emg_ptr), 32'(vecs[j].exp_ptr));
         check($sformatf("w%0d_ecg_ptr", j), 32'(ecg_ptr), 32'(vecs[j].exp_ptr));
      end
      vga_mon_en = 1'b0;
      check("vga_bad_cycles", vga_bad, 0);
      check("vga_low_cycles", vga_low, 12);
      check("frame_done_count", fd_q.size(), 1);
      if (fd_q.size() != 0) check("frame_done_cycle", fd_q[0], 130);

      // Frozen window writes nothing; freeze rising during WR_EMG still lets WR_ECG through.
      freeze = 1'b1;
      emg_in = 32'd1000;
      ecg_in = 32'd300;
      do_reset();
      wait_cyc(34);
      check("frz_no_write", wr_q.size(), 0);
      check("frz_emg_ptr", 32'(emg_ptr), 32'd0);
      check("frz_ecg_ptr", 32'(ecg_ptr), 32'd0);
      freeze = 1'b0;
      emg_in = 32'd50;
      ecg_in = 32'd60;
      wait_cyc(64);
      freeze = 1'b1;
      wait_cyc(67);
      check("frz_wr_count", wr_q.size(), 2);
      expect_write("frz_emg", 64, 12'hC7F, 32'd50);
      expect_write("frz_ecg", 65, 12'h801, 32'd60);
      wr_q.delete();
      check("frz_emg_ptr_after", 32'(emg_ptr), 32'd1);
      check("frz_ecg_ptr_after", 32'(ecg_ptr), 32'd1);
      freeze = 1'b0;

      // Reset landing in WR_EMG aborts the sequence.
      wait_cyc(96);
      reset = 1'b1;
      @(negedge clock);
      check("abort_ram_we", 32'(ram_bus.ram_we), 32'd0);
      check("abort_emg_ptr", 32'(emg_ptr), 32'd0);
      check("abort_ecg_ptr", 32'(ecg_ptr), 32'd0);
      check("abort_wr_count", wr_q.size(), 1);
      expect_write("abort_emg", 96, 12'hC80, 32'd50);
      wr_q.delete();
      fd_q.delete();
      reset = 1'b0;
      wait_cyc(31);
      check("post_rst_no_early_write", wr_q.size(), 0);
      wait_cyc(35);
      check("post_rst_wr_count", wr_q.size(), 2);
      expect_write("post_rst_emg", 32, 12'hC7F, 32'd50);
      expect_write("post_rst_ecg", 33, 12'h801, 32'd60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
